// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: upstream decode, forwarding, flush and ALU-side signals of the ID/EX stage.
interface id_ex_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_rd1;
   logic [31:0] in_rd2;
   logic [31:0] in_imm;
   logic        in_alusrc;
   logic [2:0]  in_alu_control;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [4:0]  in_rd;
   logic        in_regwrite;
   logic        fwd_mem_we;
   logic [4:0]  fwd_mem_rd;
   logic [31:0] fwd_mem_data;
   logic        fwd_wb_we;
   logic [4:0]  fwd_wb_rd;
   logic [31:0] fwd_wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic [2:0]  alu_control;
   logic [4:0]  rd;
   logic        regwrite;
   modport slave (
      input  in_valid, in_rd1, in_rd2, in_imm, in_alusrc, in_alu_control, in_rs1, in_rs2, in_rd, in_regwrite,
      input  fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data,
      input  flush, out_ready,
      output in_ready, out_valid, srca, srcb, alu_control, rd, regwrite
   );
   modport master (
      output in_valid, in_rd1, in_rd2, in_imm, in_alusrc, in_alu_control, in_rs1, in_rs2, in_rd, in_regwrite,
      output fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data,
      output flush, out_ready,
      input  in_ready, out_valid, srca, srcb, alu_control, rd, regwrite
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: two-entry (head + skid) ID/EX pipeline register with operand forwarding at capture.
// Forwarding is enabled by defining ID_EX_FORWARD_EN; otherwise the fwd_* signals are ignored.
module id_ex_stage (
   input  logic         clk,
   input  logic         reset_n,
   id_ex_stage_if.slave bus
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  alu_control;
      logic [4:0]  rd;
      logic        regwrite;
   } entry_t;
   state_t      state, state_nxt;
   entry_t      head, skid, cap;
   logic        in_ready_q, accept, pop;
   logic [31:0] opa, opb;
`ifdef ID_EX_FORWARD_EN
   // mem stage is younger than wb, so its match wins; x0 is hard-wired zero and never forwarded
   always_comb begin
      opa = (bus.fwd_mem_we && bus.fwd_mem_rd == bus.in_rs1 && bus.in_rs1 != 5'd0) ? bus.fwd_mem_data :
            (bus.fwd_wb_we  && bus.fwd_wb_rd  == bus.in_rs1 && bus.in_rs1 != 5'd0) ? bus.fwd_wb_data  : bus.in_rd1;
      opb = (bus.fwd_mem_we && bus.fwd_mem_rd == bus.in_rs2 && bus.in_rs2 != 5'd0) ? bus.fwd_mem_data :
            (bus.fwd_wb_we  && bus.fwd_wb_rd  == bus.in_rs2 && bus.in_rs2 != 5'd0) ? bus.fwd_wb_data  : bus.in_rd2;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data, bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_data};
   assign opa = bus.in_rd1;
   assign opb = bus.in_rd2;
`endif
   always_comb begin
      cap.a           = opa;
      cap.b           = bus.in_alusrc ? bus.in_imm : opb;
      cap.alu_control = bus.in_alu_control;
      cap.rd          = bus.in_rd;
      cap.regwrite    = bus.in_regwrite;
   end
   assign accept        = bus.in_valid & in_ready_q;
   assign pop           = bus.out_valid & bus.out_ready;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = state != EMPTY;
   assign bus.srca        = head.a;
   assign bus.srcb        = head.b;
   assign bus.alu_control = head.alu_control;
   assign bus.rd          = head.rd;
   assign bus.regwrite    = head.regwrite;
   always_comb begin
      state_nxt = state;
      state_nxt = bus.flush      ? EMPTY :
                  state == EMPTY ? (accept ? ONE : EMPTY) :
                  state == ONE   ? (accept && !pop ? TWO : !accept && pop ? EMPTY : ONE) :
                                   (pop ? ONE : TWO);
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_nxt;
         in_ready_q <= state_nxt != TWO;
      end
   end
   // with accept+pop in ONE the new entry goes straight to head; skid only fills when head is held
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head <= '0;
         skid <= '0;
      end else if (!bus.flush) begin
         if (state == TWO) begin
            if (pop) head <= skid;
         end else if (accept && (state == EMPTY || pop)) head <= cap;
         else if (accept) skid <= cap;
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: queue-based reference model with per-cycle comparison, plus directed literal checks.
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   id_ex_stage_if bus();
   id_ex_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
`ifdef ID_EX_FORWARD_EN
   localparam logic [31:0] EXP_MEM = 32'hAA, EXP_WB = 32'hBB;
`else
   localparam logic [31:0] EXP_MEM = 32'h11, EXP_WB = 32'h11;
`endif
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  alu;
      logic [4:0]  rd;
      logic        rw;
   } ent_t;
   ent_t q[$];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
`ifdef ID_EX_FORWARD_EN
      if (rs != 0 && bus.fwd_mem_we && bus.fwd_mem_rd == rs) return bus.fwd_mem_data;
      if (rs != 0 && bus.fwd_wb_we && bus.fwd_wb_rd == rs) return bus.fwd_wb_data;
`endif
      return rf;
   endfunction
   always @(posedge clk) begin
      ent_t e;
      bit do_push, do_pop;
      if (!reset_n || bus.flush) q.delete();
      else begin
         do_pop  = q.size() > 0 && bus.out_ready;
         do_push = bus.in_valid && q.size() < 2;
         e.a   = operand(bus.in_rs1, bus.in_rd1);
         e.b   = bus.in_alusrc ? bus.in_imm : operand(bus.in_rs2, bus.in_rd2);
         e.alu = bus.in_alu_control;
         e.rd  = bus.in_rd;
         e.rw  = bus.in_regwrite;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(e);
      end
   end
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
         chk("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
         if (q.size() > 0) begin
            chk("srca", bus.srca, q[0].a);
            chk("srcb", bus.srcb, q[0].b);
            chk("alu_control", {29'd0, bus.alu_control}, {29'd0, q[0].alu});
            chk("rd", {27'd0, bus.rd}, {27'd0, q[0].rd});
            chk("regwrite", {31'd0, bus.regwrite}, {31'd0, q[0].rw});
         end
      end
   end
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   initial begin
      bus.in_valid = 0; bus.in_rd1 = 0; bus.in_rd2 = 0; bus.in_imm = 0; bus.in_alusrc = 0;
      bus.in_alu_control = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0; bus.in_regwrite = 0;
      bus.fwd_mem_we = 0; bus.fwd_mem_rd = 0; bus.fwd_mem_data = 0;
      bus.fwd_wb_we = 0; bus.fwd_wb_rd = 0; bus.fwd_wb_data = 0;
      bus.flush = 0; bus.out_ready = 0;
      step(2);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_srca", bus.srca, 32'd0);
      chk("rst_srcb", bus.srcb, 32'd0);
      chk("rst_regwrite", {31'd0, bus.regwrite}, 32'd0);
      chk("rst_alu_rd", {24'd0, bus.alu_control, bus.rd}, 32'd0);
      reset_n = 1;
      chk_en = 1;
      // backpressure: two beats held, third stalled until a pop
      bus.in_valid = 1; bus.in_rd1 = 1; step();
      chk("bp_srca1", bus.srca, 32'd1);
      bus.in_rd1 = 2; step();
      chk("bp_ready_full", {31'd0, bus.in_ready}, 32'd0);
      bus.in_rd1 = 3; step();
      chk("bp_hold", bus.srca, 32'd1);
      bus.out_ready = 1; step();
      chk("bp_srca2", bus.srca, 32'd2);
      step();
      chk("bp_srca3", bus.srca, 32'd3);
      bus.in_valid = 0; step();
      chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);
      // forwarding priority and x0 exclusion
      bus.in_valid = 1; bus.in_rs1 = 5; bus.in_rd1 = 32'h11;
      bus.in_alu_control = 3'b110; bus.in_rd = 5'd17; bus.in_regwrite = 1;
      bus.fwd_mem_we = 1; bus.fwd_mem_rd = 5; bus.fwd_mem_data = 32'hAA;
      bus.fwd_wb_we = 1; bus.fwd_wb_rd = 5; bus.fwd_wb_data = 32'hBB;
      step();
      chk("fwd_mem", bus.srca, EXP_MEM);
      chk("pass_alu", {29'd0, bus.alu_control}, 32'd6);
      chk("pass_rd", {27'd0, bus.rd}, 32'd17);
      chk("pass_rw", {31'd0, bus.regwrite}, 32'd1);
      bus.fwd_mem_we = 0; step();
      chk("fwd_wb", bus.srca, EXP_WB);
      bus.in_rs1 = 0; bus.fwd_mem_we = 1; bus.fwd_mem_rd = 0; bus.fwd_wb_rd = 0; step();
      chk("fwd_x0", bus.srca, 32'h11);
      bus.in_alusrc = 1; bus.in_imm = 32'hFFFFFFFC; bus.in_rs2 = 5; bus.in_rd2 = 32'h22;
      bus.fwd_mem_rd = 5; bus.fwd_wb_rd = 5; step();
      chk("alusrc_imm", bus.srcb, 32'hFFFFFFFC);
      bus.in_valid = 0; bus.in_alusrc = 0; step();
      // flush while full with a simultaneous incoming beat
      bus.out_ready = 0; bus.in_valid = 1; bus.in_rd1 = 7; step();
      bus.in_rd1 = 8; step();
      bus.flush = 1; bus.in_rd1 = 9; step();
      chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.flush = 0; bus.in_valid = 0; step();
      chk("flush_dropped", {31'd0, bus.out_valid}, 32'd0);
      // reset mid-operation beats flush/accept/pop
      bus.in_valid = 1; bus.in_rd1 = 32'h5A; bus.in_regwrite = 1; step(2);
      reset_n = 0; bus.out_ready = 1; bus.flush = 1; step();
      chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mrst_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("mrst_srca", bus.srca, 32'd0);
      chk("mrst_rw", {31'd0, bus.regwrite}, 32'd0);
      reset_n = 1; bus.flush = 0; bus.in_valid = 0;
      step();
      repeat (3000) begin
         bus.in_valid       = $urandom_range(0, 3) != 0;
         bus.out_ready      = ($urandom % 3) != 0;
         bus.flush          = ($urandom % 25) == 0;
         reset_n            = ($urandom % 200) != 0;
         bus.in_rd1         = $urandom;
         bus.in_rd2         = $urandom;
         bus.in_imm         = $urandom;
         bus.in_alusrc      = $urandom_range(0, 1) != 0;
         bus.in_alu_control = 3'($urandom);
         bus.in_rs1         = 5'($urandom_range(0, 3));
         bus.in_rs2         = 5'($urandom_range(0, 3));
         bus.in_rd          = 5'($urandom);
         bus.in_regwrite    = $urandom_range(0, 1) != 0;
         bus.fwd_mem_we     = $urandom_range(0, 1) != 0;
         bus.fwd_mem_rd     = 5'($urandom_range(0, 3));
         bus.fwd_mem_data   = $urandom;
         bus.fwd_wb_we      = $urandom_range(0, 1) != 0;
         bus.fwd_wb_rd      = 5'($urandom_range(0, 3));
         bus.fwd_wb_data    = $urandom;
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, the only clock.
REQ-002 SHALL have ports: reset_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have upstream ports: in_valid in 1; in_ready out 1; in_rd1 in 32 (rs1 regfile data); in_rd2 in 32 (rs2 regfile data); in_imm in 32; in_alusrc in 1 (1 = srcb from imm); in_alu_control in 3; in_rs1, in_rs2, in_rd in 5 each; in_regwrite in 1.
REQ-004 SHALL have forwarding ports: fwd_mem_we in 1, fwd_mem_rd in 5, fwd_mem_data in 32; fwd_wb_we in 1, fwd_wb_rd in 5, fwd_wb_data in 32.
REQ-005 SHALL have control port: flush in 1 (discard all held entries).
REQ-006 SHALL have ALU-side ports: out_valid out 1; out_ready in 1; srca out 32; srcb out 32; alu_control out 3; rd out 5; regwrite out 1.

Function
REQ-007 SHALL hold up to two entries (head + skid) with occupancy states EMPTY, ONE, TWO.
REQ-008 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO; in_ready SHALL be a register output, never combinationally dependent on out_ready.
REQ-009 Accept SHALL occur when in_valid & in_ready at a rising edge; pop SHALL occur when out_valid & out_ready.
REQ-010 Transitions: EMPTY+accept->ONE; ONE+accept-only->TWO; ONE+pop-only->EMPTY; ONE+accept+pop->ONE; TWO+pop->ONE (skid moves to head); otherwise state holds.
REQ-011 out_valid SHALL be 1 exactly in ONE and TWO; outputs SHALL present the head entry and stay stable while out_valid & !out_ready.
REQ-012 Latency: an entry accepted into EMPTY SHALL appear on outputs the next cycle; FIFO order SHALL be preserved.
REQ-013 Operand A captured = forwarded value of in_rs1, else in_rd1.
REQ-014 Operand B captured = in_imm when in_alusrc = 1; else forwarded value of in_rs2, else in_rd2.
REQ-015 Forwarding SHALL resolve at capture: mem match (fwd_mem_we & fwd_mem_rd == rsN) wins over wb match; register 0 SHALL never be forwarded.
REQ-016 alu_control, rd, regwrite SHALL pass through unchanged; unused codes (100, 110, 111) SHALL be captured as-is.
REQ-017 flush SHALL force EMPTY at the next edge, overriding simultaneous accept and pop; in_ready SHALL be 1 the cycle after flush.
REQ-018 All 32-bit data SHALL be carried verbatim; no truncation or sign change.

Reset
REQ-019 With reset_n = 0 at a rising edge: state EMPTY, out_valid = 0, in_ready = 1, srca = srcb = 0, alu_control = 3'b000, rd = 0, regwrite = 0.
REQ-020 Reset mid-operation SHALL discard both entries; reset SHALL take priority over flush, accept and pop.

Configuration
REQ-021 Macro ID_EX_FORWARD_EN: defined -> REQ-015 forwarding active; undefined -> fwd_* ports present but ignored, operands taken solely from in_rd1/in_rd2/in_imm.

Verification
REQ-022 Reset: reset_n = 0 two cycles -> out_valid = 0, in_ready = 1, srca = srcb = 0, regwrite = 0.
REQ-023 Backpressure: out_ready = 0, three valid beats rd1 = 1, 2, 3 -> beats 1, 2 held, in_ready = 0 after second; out_ready = 1 -> srca 1 then 2 then 3 in order, no loss.
REQ-024 Forwarding (macro defined): in_rs1 = 5, in_rd1 = 0x11, fwd_mem 5/0xAA, fwd_wb 5/0xBB -> srca = 0xAA; mem_we = 0 -> srca = 0xBB; in_rs1 = 0, both fwd rd = 0 -> srca = 0x11.
REQ-025 alusrc: in_alusrc = 1, in_imm = 0xFFFFFFFC, fwd matching rs2 -> srcb = 0xFFFFFFFC.
REQ-026 Flush in TWO with in_valid = 1 same cycle -> next cycle out_valid = 0, in_ready = 1, incoming beat dropped.
REQ-027 Macro undefined: same stimulus as REQ-024 -> srca = 0x11.
